// File: rtl/sevseg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan driver.
// Holds the BCD FSM state enum, segment constants and the hex-to-segment LUT.
package sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } bcd_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFE;

  // Active-low a..g pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++)
      r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/sevseg_bcd_seq.sv
// Iterative double-dabble: one bit per clock, BIN_W shifts then a DONE cycle.
// Ports: clk, rst_n, start, bin in; busy, done (1-cycle pulse), bcd out.
module sevseg_bcd_seq
  import sevseg_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int BCD_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W);

  bcd_state_t       state;
  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt;

  // Add 3 to every nibble >= 5 before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++)
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin_r <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bin_r <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd   <= {adj[BCD_W-2:0], bin_r[BIN_W-1]};
          bin_r <= {bin_r[BIN_W-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed common-anode 7-seg driver: hex/decimal load, prescaled scan.
// Option macro SEVSEG_LZB_EN enables leading-zero blanking.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  MODE,
  input  logic                  DATA_VALID,
  input  logic [DATA_W-1:0]     DATA_IN,
  input  logic [NUM_DIGITS-1:0] DP_IN,
  output logic                  BUSY,
  output logic [7:0]            CATHODES,
  output logic [NUM_DIGITS-1:0] ANODES
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  logic              load_ok;
  logic              start;
  logic              load_hex;
  logic              done;
  logic [DISP_W-1:0] bcd;
  logic [DISP_W-1:0] disp;
  logic              ovf;
  logic              ovf_pend;
  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nib;
  logic [7:0]        seg_byte;

  assign load_ok  = DATA_VALID & ~BUSY;
  assign start    = load_ok & MODE;
  assign load_hex = load_ok & ~MODE;

  sevseg_bcd_seq #(
    .BIN_W(DATA_W),
    .BCD_W(DISP_W)
  ) u_bcd (
    .clk  (CLK),
    .rst_n(RST_N),
    .start(start),
    .bin  (DATA_IN),
    .busy (BUSY),
    .done (done),
    .bcd  (bcd)
  );

  // Overflow is decided at capture but only shown with the new value,
  // so the old display stays intact during the conversion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      disp     <= '0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
    end else if (load_hex) begin
      disp <= DISP_W'(DATA_IN);
      ovf  <= 1'b0;
    end else if (start) begin
      ovf_pend <= 64'(DATA_IN) > DEC_MAX;
    end else if (done) begin
      disp <= bcd;
      ovf  <= ovf_pend;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

`ifdef SEVSEG_LZB_EN
  logic [IDX_W-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (disp[4*i +: 4] != 4'h0)
        msd = IDX_W'(i);
  end
`endif

  always_comb begin
    nib      = disp[idx*4 +: 4];
    seg_byte = {1'b1, hex_to_seg(nib)};
    if (ovf)
      seg_byte = SEG_DASH;
`ifdef SEVSEG_LZB_EN
    else if (idx > msd)
      seg_byte = SEG_BLANK;
`endif
    seg_byte[7] = ~DP_IN[idx];
  end

  // Anode and cathode come from the same idx on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ANODES   <= '1;
      CATHODES <= SEG_BLANK;
    end else begin
      ANODES   <= ~(NUM_DIGITS'(1) << idx);
      CATHODES <= seg_byte;
    end
  end

endmodule
